// File: rtl/byte_write_arbiter.sv
// Two-requester round-robin arbiter with lock support for one byte-enabled register write port.
// Latency: one cycle from an accepted beat to out_byteena/out_d/out_src.
// Backpressure: readies are combinational from state, prio and valids; a locked owner holds ready, the other waits.
module byte_write_arbiter #(
  parameter int NBYTES   = 2,
  parameter int MAX_LOCK = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [NBYTES-1:0]     req0_byteena,
  input  logic [8*NBYTES-1:0]   req0_d,
  input  logic                  req0_lock,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [NBYTES-1:0]     req1_byteena,
  input  logic [8*NBYTES-1:0]   req1_d,
  input  logic                  req1_lock,
  output logic [NBYTES-1:0]     out_byteena,
  output logic [8*NBYTES-1:0]   out_d,
  output logic                  out_src,
  output logic                  lock_abort
);

  localparam int DW = 8 * NBYTES;
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_t;

  state_t          state;
  logic            prio;
  logic [CW-1:0]   cnt;

  logic            rdy0;
  logic            rdy1;
  logic            acc0;
  logic            acc1;
  logic            acc_any;
  logic [NBYTES-1:0] acc_byteena;
  logic [DW-1:0]   acc_d;
  logic            acc_lock;
  logic [CW-1:0]   cnt_inc;

  // Grant generation: locked owner always ready, otherwise single valid wins, ties go to prio.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (!reset) begin
      case (state)
        OPEN: begin
          if (req0_valid && req1_valid) begin
            rdy0 = ~prio;
            rdy1 = prio;
          end else begin
            rdy0 = req0_valid;
            rdy1 = req1_valid;
          end
        end
        LOCKED0: rdy0 = 1'b1;
        LOCKED1: rdy1 = 1'b1;
        default: begin
          rdy0 = 1'b0;
          rdy1 = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = rdy0;
  assign req1_ready = rdy1;

  // Readies are mutually exclusive, so at most one of these is high; acc1 doubles as the winner index.
  assign acc0        = req0_valid & rdy0;
  assign acc1        = req1_valid & rdy1;
  assign acc_any     = acc0 | acc1;
  assign acc_byteena = acc1 ? req1_byteena : req0_byteena;
  assign acc_d       = acc1 ? req1_d       : req0_d;
  assign acc_lock    = acc1 ? req1_lock    : req0_lock;
  assign cnt_inc     = cnt + CW'(1);

  // Arbitration state, lock counting and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= OPEN;
      prio        <= 1'b0;
      cnt         <= '0;
      out_byteena <= '0;
      out_d       <= '0;
      out_src     <= 1'b0;
      lock_abort  <= 1'b0;
    end else begin
      lock_abort <= 1'b0;
      if (acc_any) begin
        out_byteena <= acc_byteena;
        out_d       <= acc_d;
        out_src     <= acc1;
        if (acc_lock && (cnt_inc < CW'(MAX_LOCK))) begin
          // Owner keeps the port; prio is left alone until it releases.
          state <= acc1 ? LOCKED1 : LOCKED0;
          cnt   <= cnt_inc;
        end else begin
          // Voluntary release or forced release at the beat limit.
          state      <= OPEN;
          cnt        <= '0;
          prio       <= ~acc1;
          lock_abort <= acc_lock;
        end
      end else begin
        // No write this cycle: drop strobes, keep data/source stable.
        out_byteena <= '0;
      end
    end
  end

endmodule

// File: doc/byte_write_arbiter.md
Name: byte_write_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 16-bit byte-enabled register (per-byte write strobes) between two independent writers.
- Each requester presents a strobed write beat with a valid/ready handshake and may lock ownership for multi-beat sequences.
- The winning beat is registered and driven as a byteena/d pair onto the shared register's write port.
- Sits between the two write sources and the register, and owns all write sequencing for it.

Parameters:
NBYTES, 2, byte lanes of the shared register; data width is 8*NBYTES
MAX_LOCK, 16, maximum consecutive accepted beats one locked owner may hold before forced release (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a beat
req0_ready  out  1  requester 0 beat accepted this cycle when valid also high
req0_byteena  in  NBYTES  requester 0 per-byte write strobe
req0_d  in  8*NBYTES  requester 0 write data
req0_lock  in  1  keep ownership after this beat
req1_valid, req1_ready, req1_byteena, req1_d, req1_lock: same as requester 0, for requester 1
out_byteena  out  NBYTES  write strobes to shared register
out_d  out  8*NBYTES  write data to shared register
out_src  out  1  requester index of the beat on out_*
lock_abort  out  1  one-cycle pulse when a lock is force-released

Behaviour:
- State: OPEN, LOCKED0, LOCKED1; round-robin pointer prio (0 favours req0); lock counter cnt, width clog2(MAX_LOCK+1).
- Reset (synchronous, any state including mid-lock) forces:
  - state=OPEN, prio=0, cnt=0
  - out_byteena=0, out_d=0, out_src=0, lock_abort=0
  - readies low during the reset cycle
- Ready generation (combinational from state, prio and valids; never depends on byteena, d or lock):
  - OPEN, only reqK valid: readyK=1.
  - OPEN, both valid: ready goes to the requester selected by prio only.
  - OPEN, neither valid: both readies 0.
  - LOCKEDk: readyk=1 regardless of validk; other ready=0.
- Accept: valid&ready. At most one accept per cycle.
- Output stage, one-cycle latency:
  - Cycle after an accept: out_byteena=accepted byteena, out_d=accepted d, out_src=k.
  - Cycle after no accept: out_byteena=0; out_d and out_src hold their values.
- A beat with byteena=0 is accepted normally, consumes a beat and counts toward the lock limit; it produces out_byteena=0.
- Lock transitions on an accept from k:
  - lock=1, cnt+1<MAX_LOCK: state=LOCKEDk, cnt=cnt+1.
  - lock=1, cnt+1==MAX_LOCK: state=OPEN, cnt=0, prio=~k, lock_abort=1 next cycle.
  - lock=0: state=OPEN, cnt=0, prio=~k.
- MAX_LOCK=1 means every locked beat aborts immediately.
- LOCKEDk with validk low: remain locked and cnt holds. There is no idle timeout; the owner must finish with a lock=0 beat.
- Non-locked accepts in OPEN also set prio=~k, so back-to-back contention alternates 0,1,0,1.
- Requester lock inputs are sampled only on its own accepted beat.
- Output registers are updated only by accepts, so the shared register sees at most one strobed write per cycle.

Test Plan:
- Reset then idle → out_byteena=0, out_d=0x0000, lock_abort=0, both readies 0 with no valids.
- req0 alone: byteena=01, d=0xAB12, lock=0 → req0_ready=1 same cycle; next cycle out_byteena=01, out_d=0xAB12, out_src=0; cycle after, out_byteena=0.
- Both valid for 4 cycles, lock=0, from reset → grants 0,1,0,1; out_src sequence 0,1,0,1 one cycle delayed; the losing requester's ready is 0 in each cycle.
- req1 lock=1 for 3 beats then lock=0, with req0 valid throughout → req0_ready=0 for all 4 req1 beats, out_src=1 x4; next cycle req0 granted.
- MAX_LOCK=16, req0 lock=1 held continuously → 16 beats accepted; lock_abort=1 for exactly one cycle after the 16th; req1 (valid) granted next cycle.
- Assert reset while LOCKED1 with cnt=5 → next cycle state OPEN, out_byteena=0; post-reset contention grants req0 first.
